// File: rtl/bsg_dpi_tile_bridge_pkg.sv
// Shared types and sizing helpers for the DPI tile bridge.
// The bridge sits between a per-cycle DPI call site and bsg_manycore_endpoint_to_fifos_aligned.
package bsg_dpi_tile_bridge_pkg;

   typedef enum logic {
      e_rx_backpressure = 1'b0,
      e_rx_drain_drop   = 1'b1
   } rx_drain_mode_e;

   typedef enum logic [1:0] {
      e_tx_req,
      e_tx_rsp,
      e_rx_req,
      e_rx_rsp
   } channel_e;

   function automatic int outstanding_width(input int max_outstanding);
      return $clog2(max_outstanding + 1);
   endfunction

   function automatic int ptr_width(input int els);
      return (els > 1) ? $clog2(els) : 1;
   endfunction

endpackage

// File: rtl/bsg_dpi_tile_bridge_fifo.sv
// First-word-fall-through queue with registered storage: a push becomes visible one cycle later.
// ready_o is plain !full; a full queue only takes v_i when the same cycle pops.
module bsg_dpi_tile_bridge_fifo
   import bsg_dpi_tile_bridge_pkg::*;
 #(parameter int width_p = 128
   ,parameter int els_p  = 4
  )
  (input  logic               clk_i
   ,input  logic               reset_i
   ,input  logic               v_i
   ,input  logic [width_p-1:0] data_i
   ,output logic               ready_o
   ,output logic               v_o
   ,output logic [width_p-1:0] data_o
   ,input  logic               yumi_i
  );

   localparam int ptr_w_lp = ptr_width(els_p);
   localparam int cnt_w_lp = $clog2(els_p + 1);
   // A depth-1 queue still carries a 1-bit pointer; the spare entry is never written.
   localparam int mem_els_lp = (els_p > 1) ? els_p : 2;
   localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
   localparam logic [cnt_w_lp-1:0] els_lp      = cnt_w_lp'(els_p);

   logic [width_p-1:0]  mem_r [mem_els_lp];
   logic [ptr_w_lp-1:0] wptr_r, rptr_r;
   logic [cnt_w_lp-1:0] count_r;
   logic                full, empty, enq, deq;

   assign full    = (count_r == els_lp);
   assign empty   = (count_r == '0);
   assign deq     = yumi_i & ~empty;
   assign enq     = v_i & (~full | deq);
   assign ready_o = ~full;
   assign v_o     = ~empty;
   assign data_o  = mem_r[rptr_r];

   function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
      return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
   endfunction

   // NOTE: storage is not reset; an empty count already masks stale words, and skipping reset keeps it RAM-mappable.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wptr_r] <= data_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (enq) wptr_r <= next_ptr(wptr_r);
         if (deq) rptr_r <= next_ptr(rptr_r);
         if (enq & ~deq)      count_r <= count_r + cnt_w_lp'(1);
         else if (deq & ~enq) count_r <= count_r - cnt_w_lp'(1);
      end
   end

endmodule

// File: rtl/bsg_nonsynth_dpi_tile_bridge.sv
// Buffered bridge from a C/C++ tile model to the four aligned endpoint FIFO interfaces.
// Requests are gated by endpoint credits and an outstanding cap; rx traffic backpressures or drains.
module bsg_nonsynth_dpi_tile_bridge
   import bsg_dpi_tile_bridge_pkg::*;
 #(parameter int fifo_width_p       = 128
   ,parameter int tx_req_els_p      = 4
   ,parameter int tx_rsp_els_p      = 4
   ,parameter int rx_req_els_p      = 4
   ,parameter int rx_rsp_els_p      = 4
   ,parameter int max_out_credits_p = 32
   ,parameter int max_outstanding_p = 16
   ,parameter int rx_drain_mode_p   = 0
   ,parameter int cnt_width_p       = 32
   ,localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
   ,localparam int out_width_lp     = outstanding_width(max_outstanding_p)
  )
  (input  logic                       clk_i
   ,input  logic                       reset_i

   ,input  logic                       host_req_v_i
   ,input  logic [fifo_width_p-1:0]    host_req_i
   ,output logic                       host_req_ready_o
   ,input  logic                       host_rsp_v_i
   ,input  logic [fifo_width_p-1:0]    host_rsp_i
   ,output logic                       host_rsp_ready_o

   ,output logic                       host_rx_req_v_o
   ,output logic [fifo_width_p-1:0]    host_rx_req_o
   ,input  logic                       host_rx_req_yumi_i
   ,output logic                       host_rx_rsp_v_o
   ,output logic [fifo_width_p-1:0]    host_rx_rsp_o
   ,input  logic                       host_rx_rsp_yumi_i

   ,output logic                       ep_req_v_o
   ,output logic [fifo_width_p-1:0]    ep_req_o
   ,input  logic                       ep_req_ready_i
   ,output logic                       ep_rsp_v_o
   ,output logic [fifo_width_p-1:0]    ep_rsp_o
   ,input  logic                       ep_rsp_ready_i

   ,input  logic                       mc_req_v_i
   ,input  logic [fifo_width_p-1:0]    mc_req_i
   ,output logic                       mc_req_ready_o
   ,input  logic                       mc_rsp_v_i
   ,input  logic [fifo_width_p-1:0]    mc_rsp_i
   ,output logic                       mc_rsp_ready_o

   ,input  logic [credit_width_lp-1:0] out_credits_i
   ,output logic [out_width_lp-1:0]    outstanding_o
   ,output logic [cnt_width_p-1:0]     rx_req_drops_o
   ,output logic [cnt_width_p-1:0]     rx_rsp_drops_o
   ,output logic                       err_underflow_o
  );

   localparam rx_drain_mode_e drain_mode_lp =
      (rx_drain_mode_p == 1) ? e_rx_drain_drop : e_rx_backpressure;
   localparam logic drain_lp = (drain_mode_lp == e_rx_drain_drop);
   localparam logic [out_width_lp-1:0] out_max_lp = out_width_lp'(max_outstanding_p);

   logic tx_req_ready, tx_req_v, tx_rsp_ready, rx_req_ready, rx_rsp_ready;
   logic ep_req_fire, ep_rsp_fire, rx_req_drop, rx_rsp_drop, rsp_return;

   logic [out_width_lp-1:0] outstanding_r;
   logic [cnt_width_p-1:0]  rx_req_drops_r, rx_rsp_drops_r;
   logic                    err_r;

   // Host pushes are gated by ready so a push on a full queue can never slip in behind a pop.
   bsg_dpi_tile_bridge_fifo #(.width_p(fifo_width_p), .els_p(tx_req_els_p)) tx_req_fifo
     (.clk_i   (clk_i)
      ,.reset_i(reset_i)
      ,.v_i    (host_req_v_i & tx_req_ready)
      ,.data_i (host_req_i)
      ,.ready_o(tx_req_ready)
      ,.v_o    (tx_req_v)
      ,.data_o (ep_req_o)
      ,.yumi_i (ep_req_fire)
     );

   bsg_dpi_tile_bridge_fifo #(.width_p(fifo_width_p), .els_p(tx_rsp_els_p)) tx_rsp_fifo
     (.clk_i   (clk_i)
      ,.reset_i(reset_i)
      ,.v_i    (host_rsp_v_i & tx_rsp_ready)
      ,.data_i (host_rsp_i)
      ,.ready_o(tx_rsp_ready)
      ,.v_o    (ep_rsp_v_o)
      ,.data_o (ep_rsp_o)
      ,.yumi_i (ep_rsp_fire)
     );

   bsg_dpi_tile_bridge_fifo #(.width_p(fifo_width_p), .els_p(rx_req_els_p)) rx_req_fifo
     (.clk_i   (clk_i)
      ,.reset_i(reset_i)
      ,.v_i    (mc_req_v_i & mc_req_ready_o)
      ,.data_i (mc_req_i)
      ,.ready_o(rx_req_ready)
      ,.v_o    (host_rx_req_v_o)
      ,.data_o (host_rx_req_o)
      ,.yumi_i (host_rx_req_yumi_i)
     );

   bsg_dpi_tile_bridge_fifo #(.width_p(fifo_width_p), .els_p(rx_rsp_els_p)) rx_rsp_fifo
     (.clk_i   (clk_i)
      ,.reset_i(reset_i)
      ,.v_i    (mc_rsp_v_i & mc_rsp_ready_o)
      ,.data_i (mc_rsp_i)
      ,.ready_o(rx_rsp_ready)
      ,.v_o    (host_rx_rsp_v_o)
      ,.data_o (host_rx_rsp_o)
      ,.yumi_i (host_rx_rsp_yumi_i)
     );

   assign host_req_ready_o = tx_req_ready;
   assign host_rsp_ready_o = tx_rsp_ready;

   assign ep_req_v_o  = tx_req_v & (out_credits_i != '0) & (outstanding_r < out_max_lp);
   assign ep_req_fire = ep_req_v_o & ep_req_ready_i;
   assign ep_rsp_fire = ep_rsp_v_o & ep_rsp_ready_i;

   // In drain mode the fifo itself accepts a full-queue arrival when the host pops that cycle.
   assign mc_req_ready_o = drain_lp | rx_req_ready;
   assign mc_rsp_ready_o = drain_lp | rx_rsp_ready;
   assign rx_req_drop = drain_lp & mc_req_v_i & ~rx_req_ready & ~host_rx_req_yumi_i;
   assign rx_rsp_drop = drain_lp & mc_rsp_v_i & ~rx_rsp_ready & ~host_rx_rsp_yumi_i;
   assign rsp_return  = (mc_rsp_v_i & mc_rsp_ready_o) | rx_rsp_drop;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         outstanding_r <= '0;
         err_r         <= 1'b0;
      end else if (ep_req_fire & ~rsp_return) begin
         outstanding_r <= outstanding_r + out_width_lp'(1);
      end else if (rsp_return & ~ep_req_fire) begin
         if (outstanding_r == '0) err_r <= 1'b1;
         else                     outstanding_r <= outstanding_r - out_width_lp'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rx_req_drops_r <= '0;
         rx_rsp_drops_r <= '0;
      end else begin
         if (rx_req_drop & ~(&rx_req_drops_r)) rx_req_drops_r <= rx_req_drops_r + cnt_width_p'(1);
         if (rx_rsp_drop & ~(&rx_rsp_drops_r)) rx_rsp_drops_r <= rx_rsp_drops_r + cnt_width_p'(1);
      end
   end

   assign outstanding_o   = outstanding_r;
   assign rx_req_drops_o  = rx_req_drops_r;
   assign rx_rsp_drops_o  = rx_rsp_drops_r;
   assign err_underflow_o = err_r;

endmodule

// File: tb/tb_bsg_nonsynth_dpi_tile_bridge.sv
// Scoreboard bench for the DPI tile bridge: one backpressure and one drain-mode instance,
// each with its own queue-level reference model, driver and monitor.
module tb_bsg_nonsynth_dpi_tile_bridge;

   localparam int fw_lp       = 32;
   localparam int txq_lp      = 4;
   localparam int txs_lp      = 1;
   localparam int rxq_lp      = 2;
   localparam int rxs_lp      = 2;
   localparam int cred_lp     = 8;
   localparam int maxo_lp     = 2;
   localparam int cw_lp       = 3;
   localparam int credw_lp    = $clog2(cred_lp + 1);
   localparam int outw_lp     = $clog2(maxo_lp + 1);
   localparam int drop_max_lp = (1 << cw_lp) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   int p_req, p_rsp, p_ep_req_rdy, p_ep_rsp_rdy, p_yumi, p_mc_req, p_mc_rsp, cred_lo, cred_hi;

   always #5 clk = ~clk;

   task automatic check(input int mode, input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL mode%0d %s: got %0h expected %0h at %0t", mode, name, act, exp, $time);
      end
   endtask

   function automatic bit roll(input int pct);
      return (int'($urandom_range(99)) < pct);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_mode
      logic                host_req_v, host_rsp_v, host_req_ready, host_rsp_ready;
      logic [fw_lp-1:0]    host_req, host_rsp;
      logic                host_rx_req_v, host_rx_rsp_v, host_rx_req_yumi, host_rx_rsp_yumi;
      logic [fw_lp-1:0]    host_rx_req, host_rx_rsp;
      logic                ep_req_v, ep_rsp_v, ep_req_ready, ep_rsp_ready;
      logic [fw_lp-1:0]    ep_req, ep_rsp;
      logic                mc_req_v, mc_rsp_v, mc_req_ready, mc_rsp_ready;
      logic [fw_lp-1:0]    mc_req, mc_rsp;
      logic [credw_lp-1:0] out_credits;
      logic [outw_lp-1:0]  outstanding;
      logic [cw_lp-1:0]    rx_req_drops, rx_rsp_drops;
      logic                err_underflow;

      bsg_nonsynth_dpi_tile_bridge #(
         .fifo_width_p(fw_lp), .tx_req_els_p(txq_lp), .tx_rsp_els_p(txs_lp),
         .rx_req_els_p(rxq_lp), .rx_rsp_els_p(rxs_lp), .max_out_credits_p(cred_lp),
         .max_outstanding_p(maxo_lp), .rx_drain_mode_p(g), .cnt_width_p(cw_lp)
      ) dut (
         .clk_i(clk), .reset_i(rst),
         .host_req_v_i(host_req_v), .host_req_i(host_req), .host_req_ready_o(host_req_ready),
         .host_rsp_v_i(host_rsp_v), .host_rsp_i(host_rsp), .host_rsp_ready_o(host_rsp_ready),
         .host_rx_req_v_o(host_rx_req_v), .host_rx_req_o(host_rx_req), .host_rx_req_yumi_i(host_rx_req_yumi),
         .host_rx_rsp_v_o(host_rx_rsp_v), .host_rx_rsp_o(host_rx_rsp), .host_rx_rsp_yumi_i(host_rx_rsp_yumi),
         .ep_req_v_o(ep_req_v), .ep_req_o(ep_req), .ep_req_ready_i(ep_req_ready),
         .ep_rsp_v_o(ep_rsp_v), .ep_rsp_o(ep_rsp), .ep_rsp_ready_i(ep_rsp_ready),
         .mc_req_v_i(mc_req_v), .mc_req_i(mc_req), .mc_req_ready_o(mc_req_ready),
         .mc_rsp_v_i(mc_rsp_v), .mc_rsp_i(mc_rsp), .mc_rsp_ready_o(mc_rsp_ready),
         .out_credits_i(out_credits), .outstanding_o(outstanding),
         .rx_req_drops_o(rx_req_drops), .rx_rsp_drops_o(rx_rsp_drops),
         .err_underflow_o(err_underflow)
      );

      // Reference model: queue occupancies, outstanding count, drop counts and the sticky error.
      int n_req = 0, n_rsp = 0, n_rxq = 0, n_rxs = 0, n_out = 0, n_drq = 0, n_drs = 0;
      bit m_err = 1'b0;
      logic [fw_lp-1:0] exp_ep_req[$], exp_ep_rsp[$], exp_rx_req[$], exp_rx_rsp[$];

      initial begin : model
         bit req_fire, rsp_fire, req_push, rsp_push, rxq_pop, rxs_pop;
         bit rxq_push, rxs_push, rxq_drop, rxs_drop, rsp_dec;
         forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
               n_req = 0; n_rsp = 0; n_rxq = 0; n_rxs = 0;
               n_out = 0; n_drq = 0; n_drs = 0; m_err = 1'b0;
               exp_ep_req.delete(); exp_ep_rsp.delete();
               exp_rx_req.delete(); exp_rx_rsp.delete();
            end else begin
               req_fire = (n_req > 0) && (out_credits != 0) && (n_out < maxo_lp) && ep_req_ready;
               rsp_fire = (n_rsp > 0) && ep_rsp_ready;
               req_push = host_req_v && (n_req < txq_lp);
               rsp_push = host_rsp_v && (n_rsp < txs_lp);
               rxq_pop  = host_rx_req_yumi && (n_rxq > 0);
               rxs_pop  = host_rx_rsp_yumi && (n_rxs > 0);
               if (g == 0) begin
                  rxq_push = mc_req_v && (n_rxq < rxq_lp);
                  rxs_push = mc_rsp_v && (n_rxs < rxs_lp);
               end else begin
                  rxq_push = mc_req_v && ((n_rxq < rxq_lp) || rxq_pop);
                  rxs_push = mc_rsp_v && ((n_rxs < rxs_lp) || rxs_pop);
               end
               rxq_drop = (g == 1) && mc_req_v && !rxq_push;
               rxs_drop = (g == 1) && mc_rsp_v && !rxs_push;
               rsp_dec  = rxs_push || rxs_drop;

               if (req_push) exp_ep_req.push_back(host_req);
               if (rsp_push) exp_ep_rsp.push_back(host_rsp);
               if (rxq_push) exp_rx_req.push_back(mc_req);
               if (rxs_push) exp_rx_rsp.push_back(mc_rsp);
               n_req += int'(req_push) - int'(req_fire);
               n_rsp += int'(rsp_push) - int'(rsp_fire);
               n_rxq += int'(rxq_push) - int'(rxq_pop);
               n_rxs += int'(rxs_push) - int'(rxs_pop);

               if (req_fire && !rsp_dec) n_out++;
               else if (rsp_dec && !req_fire) begin
                  if (n_out == 0) m_err = 1'b1;
                  else            n_out--;
               end
               if (rxq_drop && n_drq < drop_max_lp) n_drq++;
               if (rxs_drop && n_drs < drop_max_lp) n_drs++;
            end
         end
      end

      // Driver: legal random traffic shaped by the current phase knobs.
      initial begin : driver
         host_req_v = 0; host_rsp_v = 0; host_rx_req_yumi = 0; host_rx_rsp_yumi = 0;
         ep_req_ready = 0; ep_rsp_ready = 0; mc_req_v = 0; mc_rsp_v = 0;
         host_req = '0; host_rsp = '0; mc_req = '0; mc_rsp = '0; out_credits = '0;
         forever begin
            @(posedge clk);
            #1;
            host_req = $urandom; host_rsp = $urandom; mc_req = $urandom; mc_rsp = $urandom;
            if (rst) begin
               host_req_v = 0; host_rsp_v = 0; host_rx_req_yumi = 0; host_rx_rsp_yumi = 0;
               ep_req_ready = 0; ep_rsp_ready = 0; mc_req_v = 0; mc_rsp_v = 0;
               out_credits = '0;
            end else begin
               host_req_v       = (n_req < txq_lp) && roll(p_req);
               host_rsp_v       = (n_rsp < txs_lp) && roll(p_rsp);
               host_rx_req_yumi = (n_rxq > 0) && roll(p_yumi);
               host_rx_rsp_yumi = (n_rxs > 0) && roll(p_yumi);
               ep_req_ready     = roll(p_ep_req_rdy);
               ep_rsp_ready     = roll(p_ep_rsp_rdy);
               mc_req_v         = roll(p_mc_req);
               mc_rsp_v         = roll(p_mc_rsp);
               out_credits      = credw_lp'($urandom_range(cred_hi, cred_lo));
            end
         end
      end

      // Monitor: status every negedge, payloads whenever the DUT completes a handshake.
      initial begin : monitor
         logic [fw_lp-1:0] d;
         forever begin
            @(negedge clk);
            if (!rst) begin
               check(g, "host_req_ready", host_req_ready, n_req < txq_lp);
               check(g, "host_rsp_ready", host_rsp_ready, n_rsp < txs_lp);
               check(g, "ep_req_v", ep_req_v, (n_req > 0) && (out_credits != 0) && (n_out < maxo_lp));
               check(g, "ep_rsp_v", ep_rsp_v, n_rsp > 0);
               check(g, "host_rx_req_v", host_rx_req_v, n_rxq > 0);
               check(g, "host_rx_rsp_v", host_rx_rsp_v, n_rxs > 0);
               check(g, "mc_req_ready", mc_req_ready, (g == 1) || (n_rxq < rxq_lp));
               check(g, "mc_rsp_ready", mc_rsp_ready, (g == 1) || (n_rxs < rxs_lp));
               check(g, "outstanding", outstanding, n_out);
               check(g, "rx_req_drops", rx_req_drops, n_drq);
               check(g, "rx_rsp_drops", rx_rsp_drops, n_drs);
               check(g, "err_underflow", err_underflow, m_err);
               if (ep_req_v && ep_req_ready) begin
                  if (exp_ep_req.size() == 0) check(g, "ep_req_unexpected", ep_req_v, 0);
                  else begin d = exp_ep_req.pop_front(); check(g, "ep_req_data", ep_req, d); end
               end
               if (ep_rsp_v && ep_rsp_ready) begin
                  if (exp_ep_rsp.size() == 0) check(g, "ep_rsp_unexpected", ep_rsp_v, 0);
                  else begin d = exp_ep_rsp.pop_front(); check(g, "ep_rsp_data", ep_rsp, d); end
               end
               if (host_rx_req_v && host_rx_req_yumi) begin
                  if (exp_rx_req.size() == 0) check(g, "rx_req_unexpected", host_rx_req_v, 0);
                  else begin d = exp_rx_req.pop_front(); check(g, "rx_req_data", host_rx_req, d); end
               end
               if (host_rx_rsp_v && host_rx_rsp_yumi) begin
                  if (exp_rx_rsp.size() == 0) check(g, "rx_rsp_unexpected", host_rx_rsp_v, 0);
                  else begin d = exp_rx_rsp.pop_front(); check(g, "rx_rsp_data", host_rx_rsp, d); end
               end
            end
         end
      end

      // Reset is asserted away from the clock edge, so outputs must clear without a clock.
      initial begin : reset_watch
         forever begin
            @(posedge rst);
            #1;
            check(g, "rst_ep_req_v", ep_req_v, 0);
            check(g, "rst_ep_rsp_v", ep_rsp_v, 0);
            check(g, "rst_rx_req_v", host_rx_req_v, 0);
            check(g, "rst_rx_rsp_v", host_rx_rsp_v, 0);
            check(g, "rst_outstanding", outstanding, 0);
            check(g, "rst_req_drops", rx_req_drops, 0);
            check(g, "rst_rsp_drops", rx_rsp_drops, 0);
            check(g, "rst_err", err_underflow, 0);
            check(g, "rst_host_req_ready", host_req_ready, 1);
            check(g, "rst_mc_rsp_ready", mc_rsp_ready, 1);
         end
      end
   end

   task automatic run_phase(input int cycles, input int preq, input int prsp, input int perdy,
                            input int prsprdy, input int pyumi, input int pmcq, input int pmcs,
                            input int clo, input int chi);
      p_req = preq; p_rsp = prsp; p_ep_req_rdy = perdy; p_ep_rsp_rdy = prsprdy;
      p_yumi = pyumi; p_mc_req = pmcq; p_mc_rsp = pmcs; cred_lo = clo; cred_hi = chi;
      repeat (cycles) @(posedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin : control
      p_req = 0; p_rsp = 0; p_ep_req_rdy = 0; p_ep_rsp_rdy = 0;
      p_yumi = 0; p_mc_req = 0; p_mc_rsp = 0; cred_lo = 0; cred_hi = 0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;

      run_phase(30,  80, 80,   0,   0,   0,   0,   0, 8, 8);  // fill tx queues, no drain
      run_phase(20,  50, 50, 100, 100,   0,   0,   0, 1, 8);  // hit the outstanding cap
      run_phase(20,  30, 30, 100, 100,   0,   0,  25, 1, 8);  // responses release the cap
      run_phase(20,  50, 50, 100, 100,  50,  30,  30, 0, 0);  // no credits
      run_phase(40,  30, 30,  80,  80,   0,  90,  90, 1, 8);  // rx flood, host never pops
      run_phase(40,  30, 30,  80,  80, 100, 100, 100, 1, 8);  // arrivals meet pops on full queues
      run_phase(500, 50, 50,  50,  50,  50,  50,  50, 0, 8);
      run_phase(10,  80,  0,   0,   0,   0,  60,   0, 8, 8);  // partly full queues, then reset
      pulse_reset();
      run_phase(30,  50, 50, 100, 100,   0,   0,   0, 1, 8);
      run_phase(500, 60, 40,  60,  40,  40,  60,  60, 0, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bsg_nonsynth_dpi_tile_bridge.md
Name: bsg_nonsynth_dpi_tile_bridge

Overview:
Buffered, parametrised bridge between a C/C++ tile model and the four aligned FIFO interfaces of bsg_manycore_endpoint_to_fifos_aligned. It is the next generation of the DPI tile socket and is driven by per-cycle DPI calls.
- Each of the four channels gets a configurable-depth queue.
- Incoming traffic either applies backpressure or always drains, with overflow accounting.
- Issued requests are gated by an outstanding-request limit and by endpoint credits.
- Sits between the DPI call site (host side) and the endpoint (network side).

Parameters:
- fifo_width_p, 128, packet width of every channel.
- tx_req_els_p, 4, depth of host->network request queue.
- tx_rsp_els_p, 4, depth of host->network response queue.
- rx_req_els_p, 4, depth of network->host request queue.
- rx_rsp_els_p, 4, depth of network->host response queue.
- max_out_credits_p, 32, endpoint credit count.
- max_outstanding_p, 16, cap on issued-but-unanswered requests (1..max_out_credits_p).
- rx_drain_mode_p, 0: 0 = backpressure; 1 = always drain, drop on full.
- cnt_width_p, 32, width of drop counters.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- host_req_v_i / host_req_i / host_req_ready_o  in/in/out  1/fifo_width_p/1  host pushes outgoing request.
- host_rsp_v_i / host_rsp_i / host_rsp_ready_o  in/in/out  1/fifo_width_p/1  host pushes outgoing response.
- host_rx_req_v_o / host_rx_req_o / host_rx_req_yumi_i  out/out/in  1/fifo_width_p/1  host pops incoming request.
- host_rx_rsp_v_o / host_rx_rsp_o / host_rx_rsp_yumi_i  out/out/in  1/fifo_width_p/1  host pops incoming response.
- ep_req_v_o / ep_req_o / ep_req_ready_i  out/out/in  1/fifo_width_p/1  to endpoint_req_*.
- ep_rsp_v_o / ep_rsp_o / ep_rsp_ready_i  out/out/in  1/fifo_width_p/1  to endpoint_rsp_*.
- mc_req_v_i / mc_req_i / mc_req_ready_o  in/in/out  1/fifo_width_p/1  from mc_req_*.
- mc_rsp_v_i / mc_rsp_i / mc_rsp_ready_o  in/in/out  1/fifo_width_p/1  from mc_rsp_*.
- out_credits_i  in  $clog2(max_out_credits_p+1)  endpoint credits.
- outstanding_o  out  $clog2(max_outstanding_p+1)  issued-unanswered count.
- rx_req_drops_o / rx_rsp_drops_o  out  cnt_width_p  drop counts (mode 1 only; 0 otherwise).
- err_underflow_o  out  1  sticky: response arrived with outstanding_o==0.

Behaviour:
- Reset (async assert, sync-to-clock release): all queues empty; all v_o=0; outstanding_o=0; drop counters 0; err_underflow_o=0; in mode 1, mc_*_ready_o=1 immediately after release.
- Queues: first-word-fall-through, registered storage, push->visible-at-pop latency 1 cycle. No same-cycle bypass.
- Host push ready: host_*_ready_o = !full. A push while full is illegal and the host must not issue it. Simultaneous push and pop on a full queue is also refused: ready stays low that cycle.
- ep_req_v_o = tx_req nonempty && out_credits_i!=0 && outstanding_o<max_outstanding_p. The queue pops on ep_req_v_o & ep_req_ready_i.
- ep_rsp_v_o = tx_rsp nonempty. There is no credit gating; the queue pops on ep_rsp_v_o & ep_rsp_ready_i.
- Outstanding counter:
  - +1 on an ep_req handshake.
  - -1 on an mc_rsp accept (mc_rsp_v_i & mc_rsp_ready_o), or on a mode-1 drop of an mc_rsp.
  - Both in one cycle: unchanged.
  - Decrement at 0: hold at 0 and set err_underflow_o, which clears only on reset.
  - Never exceeds max_outstanding_p.
- Mode 0: mc_*_ready_o = rx queue !full.
- Mode 1: mc_*_ready_o=1. A valid arriving while the rx queue is full and not popping that cycle is discarded and the matching drop counter increments. Counters saturate at all-ones; they do not wrap.
- A host pop in the same cycle as an mc arrival on a full queue frees a slot, so the arrival is accepted with no drop.
- Pointers wrap modulo depth. Depth 1 is legal and gives alternating full/empty.
- Reset mid-traffic discards all queued packets and does not emit partial state.

Decomposition:
- Package bsg_dpi_tile_bridge_pkg holds:
  - enum rx_drain_mode_e {e_rx_backpressure, e_rx_drain_drop};
  - channel index enum {e_tx_req, e_tx_rsp, e_rx_req, e_rx_rsp};
  - a function computing the outstanding width.
- One sub-module, bsg_dpi_tile_bridge_fifo: a parametrised width/depth FIFO with async reset, full/empty, and ready/valid in and valid/yumi out. It is instantiated four times.
- The outstanding counter and drop counters stay inline.

Test Plan:
- Reset with queues partly full (3 tx_req entries), assert reset_i mid-cycle -> all v_o drop to 0 asynchronously; outstanding_o=0; after release, host_req_ready_o=1.
- max_outstanding_p=2, push 4 requests, ep_req_ready_i=1, no responses -> exactly 2 ep_req handshakes, outstanding_o=2, ep_req_v_o=0. Inject 1 mc_rsp -> 3rd request issues next cycle.
- out_credits_i=0 with tx_req nonempty -> ep_req_v_o=0. Raise to 5 -> issue in the same cycle.
- Mode 0, rx_req_els_p=2, 3 back-to-back mc_req, host never pops -> mc_req_ready_o low on the 3rd; no loss. Pop 1 -> 3rd accepted.
- Mode 1, rx_rsp_els_p=2, 5 mc_rsp, no pops -> rx_rsp_drops_o=3, outstanding decremented 5 times (saturating at 0 and setting err_underflow_o if it was below 5).
- Same cycle: ep_req handshake plus mc_rsp accept at outstanding_o=1 -> stays 1. mc_rsp at outstanding_o=0 -> stays 0, err_underflow_o=1.
